output_sram_arbiter: RTL

//  Shares the single output-SRAM write port between the NUM_REQ vertex buffer banks.
//  - Each bank presents a Bank_Req2Req_Output_SRAM packet.
//  - The arbiter picks one requester per cycle by round-robin and returns a one-hot req_grant.
//  - It registers the winning packet into a one-entry output stage.
//  - It holds that stage under SRAM backpressure.

---
 rtl/output_sram_arbiter_pkg.sv | 23 ++
 rtl/output_sram_arbiter_rr_pick.sv | 30 +++
 rtl/output_sram_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/output_sram_arbiter_pkg.sv
// Shared types for the output SRAM arbiter: bank request packet and arbiter FSM states.
`ifndef Num_Vertex_Unit
`define Num_Vertex_Unit 4
`endif

package output_sram_arbiter_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } Bank_Req2Req_Output_SRAM;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        STALL
    } arb_state_t;

endpackage

// File: rtl/output_sram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping to 0.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IW'((32'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = j;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_sram_arbiter.sv
// Round-robin arbiter sharing the output SRAM write port across vertex buffer banks.
// Optional burst hold (last winner keeps priority up to MAX_BURST grants) via ARB_BURST_HOLD_EN.
module output_sram_arbiter
    import output_sram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = `Num_Vertex_Unit,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  Bank_Req2Req_Output_SRAM bank_pkt [NUM_REQ],
    input  logic                    sram_ready,
    output logic [NUM_REQ-1:0]      req_grant,
    output Bank_Req2Req_Output_SRAM sram_pkt,
    output logic                    sram_valid,
    output logic                    idle,
    output logic [CNT_W-1:0]        xfer_cnt
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
        $error("output_sram_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    Bank_Req2Req_Output_SRAM sram_pkt_q;
    logic [CNT_W-1:0]        xfer_cnt_q;
    logic [NUM_REQ-1:0]      req_vec, pick_grant;
    logic [IW-1:0]           winner, winner_inc;
    logic                    accept, granted;

    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = bank_pkt[i].req;
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (winner)
    );

    assign sram_valid = (state_q != IDLE);
    assign accept     = !sram_valid || sram_ready;
    // Grant is masked during reset so nothing appears granted while the stage is being cleared.
    assign granted    = accept && !reset && (|req_vec);
    assign req_grant  = granted ? pick_grant : '0;
    assign winner_inc = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign idle       = !sram_valid && !(|req_vec);
    assign sram_pkt   = sram_pkt_q;
    assign xfer_cnt   = xfer_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (granted) state_d = XFER;
            end
            XFER, STALL: begin
                if (granted)         state_d = XFER;
                else if (sram_ready) state_d = IDLE;
                else                 state_d = STALL;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_BURST_HOLD_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_next;

    // A nonzero burst_cnt means rr_ptr_q is parked on the current burst holder.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        burst_next  = (winner == rr_ptr_q && burst_cnt_q != '0) ? burst_cnt_q + 1'b1 : BW'(1);
        if (granted) begin
            if (burst_next == BW'(MAX_BURST)) begin
                rr_ptr_d    = winner_inc;
                burst_cnt_d = '0;
            end else begin
                rr_ptr_d    = winner;
                burst_cnt_d = burst_next;
            end
        end else if (burst_cnt_q != '0 && !req_vec[rr_ptr_q]) begin
            rr_ptr_d    = (rr_ptr_q == IW'(NUM_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) burst_cnt_q <= '0;
        else       burst_cnt_q <= burst_cnt_d;
    end
`else
    always_comb begin
        rr_ptr_d = granted ? winner_inc : rr_ptr_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sram_pkt_q <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (granted) sram_pkt_q <= bank_pkt[winner];
            if (sram_valid && sram_ready) xfer_cnt_q <= xfer_cnt_q + 1'b1;
        end
    end

endmodule
